// File: rtl/keypad_cmd_encoder.sv
`timescale 1ns/100ps
// keypad_cmd_encoder: scans a 4x4 active-low keypad, debounces one key and issues it as a single-cycle cmd pulse to calc_top.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols,
  input  logic [1:0] status,
  output logic [3:0] rows,
  output logic [3:0] cmd,
  output logic       key_pending
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE - 1);
  localparam logic [2:0] S_SCAN  = 3'd0;
  localparam logic [2:0] S_DEB   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;
  // Nibble i holds the code of key (row, col) with i = row*4 + col; r3/c3 is never encoded.
  localparam logic [63:0] KEYMAP = 64'hFE0DC987B654A321;
  logic [2:0]    state;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [MW-1:0] match;
  logic [3:0]    sync1, sync2, first, code, enc;
  logic          at_sample, one_low, valid;
  always_comb begin
    at_sample = dwell == DWELL_LAST;
    one_low   = (sync2 == 4'b1110) || (sync2 == 4'b1101) || (sync2 == 4'b1011) || (sync2 == 4'b0111);
    col       = sync2 == 4'b1110 ? 2'd0 : sync2 == 4'b1101 ? 2'd1 : sync2 == 4'b1011 ? 2'd2 : 2'd3;
    valid     = one_low && !(row == 2'd3 && col == 2'd3);
    enc       = KEYMAP[{row, col, 2'b00} +: 4];
  end
  assign rows        = ~(4'b0001 << row);
  assign key_pending = state == S_WAIT;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_SCAN;
      row   <= 2'd0;
      dwell <= '0;
      match <= '0;
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      first <= 4'hF;
      code  <= 4'hF;
      cmd   <= 4'hF;
    end else begin
      sync1 <= cols;
      sync2 <= sync1;
      case (state)
        S_SCAN: begin
          dwell <= at_sample ? '0 : dwell + 1'b1;
          if (at_sample && valid) begin
            first <= sync2;
            code  <= enc;
            match <= MW'(1);
            state <= DEBOUNCE == 1 ? S_WAIT : S_DEB;
          end else if (at_sample)
            row <= row + 1'b1;
        end
        S_DEB: begin
          dwell <= at_sample ? '0 : dwell + 1'b1;
          if (at_sample && sync2 == first) begin
            match <= match == MATCH_LAST ? '0 : match + 1'b1;
            state <= match == MATCH_LAST ? S_WAIT : S_DEB;
          end else if (at_sample) begin
            match <= '0;
            row   <= row + 1'b1;
            state <= S_SCAN;
          end
        end
        S_WAIT: begin
          if (status == 2'b10) begin
            cmd   <= code;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmd   <= 4'hF;
          match <= '0;
          dwell <= '0;
          state <= S_REL;
        end
        S_REL: begin
          dwell <= at_sample ? '0 : dwell + 1'b1;
          // Release is judged on the frozen row only; any low column restarts the count.
          if (at_sample && sync2 == 4'hF && match == MATCH_LAST) begin
            match <= '0;
            row   <= row + 1'b1;
            state <= S_SCAN;
          end else if (at_sample)
            match <= sync2 == 4'hF ? match + 1'b1 : '0;
        end
        default: state <= S_SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_cmd_encoder.sv
`timescale 1ns/100ps
// tb_keypad_cmd_encoder: directed scenarios against a behavioural 4x4 key matrix.
module tb_keypad_cmd_encoder;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cols;
  logic [1:0]  status = 2'b10;
  logic [3:0]  rows, cmd;
  logic        key_pending;
  logic [15:0] keys = '0;
  int errors = 0;
  int checks = 0;

  keypad_cmd_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock(clock), .reset(reset), .cols(cols), .status(status),
    .rows(rows), .cmd(cmd), .key_pending(key_pending)
  );

  always #1 clock = ~clock;

  // Key index is row*4 + col; a pressed key pulls its column low while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
  end

  task automatic watch(input int n, output int pulses, output logic [3:0] code, output bit dbl);
    bit prev;
    pulses = 0; code = 4'hF; dbl = 0; prev = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (cmd !== 4'hF) begin
        pulses++;
        code = cmd;
        if (prev) dbl = 1;
        prev = 1;
      end else prev = 0;
    end
  endtask

  task automatic test_reset;
    #0.3 reset = 1'b1;
    #0.3;
    checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows got=%b exp=1110", rows); end
    checks++; if (cmd !== 4'b1111) begin errors++; $display("FAIL reset_cmd got=%b exp=1111", cmd); end
    checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", key_pending); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_key;
    int p; logic [3:0] k; bit d;
    status = 2'b10;
    keys[1] = 1'b1;
    watch(30, p, k, d);
    checks++; if (p !== 1 || k !== 4'b0010) begin errors++; $display("FAIL key2_pulse got=%0d/%b exp=1/0010", p, k); end
    watch(30, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL key2_held_extra got=%0d exp=0", p); end
    keys[1] = 1'b0;
    watch(30, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL key2_release got=%0d exp=0", p); end
    keys[11] = 1'b1;
    watch(60, p, k, d);
    checks++; if (p !== 1 || k !== 4'b1100 || d) begin errors++; $display("FAIL mul_pulse got=%0d/%b dbl=%0d exp=1/1100", p, k, d); end
    keys[11] = 1'b0;
    watch(40, p, k, d);
  endtask

  task automatic test_ready_gating;
    int p; logic [3:0] k; bit d;
    status = 2'b00;
    keys[5] = 1'b1;
    watch(60, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL gate_no_cmd got=%0d exp=0", p); end
    checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL gate_pending got=%b exp=1", key_pending); end
    keys[5] = 1'b0;
    watch(20, p, k, d);
    checks++; if (key_pending !== 1'b1 || p !== 0) begin errors++; $display("FAIL gate_release_kept got=%b/%0d exp=1/0", key_pending, p); end
    status = 2'b10;
    @(negedge clock);
    checks++; if (cmd !== 4'b0101) begin errors++; $display("FAIL gate_cmd got=%b exp=0101", cmd); end
    checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL gate_pending_fall got=%b exp=0", key_pending); end
    @(negedge clock);
    checks++; if (cmd !== 4'b1111) begin errors++; $display("FAIL gate_one_cycle got=%b exp=1111", cmd); end
    watch(40, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL gate_after got=%0d exp=0", p); end
  endtask

  task automatic test_bounce;
    int p, tot; logic [3:0] k; bit d;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      keys[14] = ~keys[14];
      watch(4, p, k, d);
      tot += p;
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL bounce_press got=%0d exp=0", tot); end
    keys[14] = 1'b1;
    watch(60, p, k, d);
    checks++; if (p !== 1 || k !== 4'b1110 || d) begin errors++; $display("FAIL bounce_stable got=%0d/%b dbl=%0d exp=1/1110", p, k, d); end
    tot = 0;
    for (int i = 0; i < 12; i++) begin
      keys[14] = ~keys[14];
      watch(4, p, k, d);
      tot += p;
    end
    keys[14] = 1'b0;
    watch(40, p, k, d);
    tot += p;
    checks++; if (tot !== 0) begin errors++; $display("FAIL bounce_release got=%0d exp=0", tot); end
  endtask

  task automatic test_multi_key;
    int p; logic [3:0] k; bit d;
    keys[4] = 1'b1; keys[5] = 1'b1;
    watch(60, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL two_cols got=%0d exp=0", p); end
    keys = '0;
    watch(20, p, k, d);
    keys[15] = 1'b1;
    watch(60, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL unused_key got=%0d exp=0", p); end
    keys = '0;
    watch(20, p, k, d);
    keys[0] = 1'b1;
    watch(60, p, k, d);
    checks++; if (p !== 1 || k !== 4'b0001) begin errors++; $display("FAIL key1_pulse got=%0d/%b exp=1/0001", p, k); end
    keys[10] = 1'b1;
    watch(80, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL key9_masked got=%0d/%b exp=0", p, k); end
    keys = '0;
    watch(40, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL both_release got=%0d exp=0", p); end
  endtask

  task automatic test_reset_mid;
    int p; logic [3:0] k; bit d;
    status = 2'b00;
    keys[8] = 1'b1;
    watch(60, p, k, d);
    checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL key7_pending got=%b exp=1", key_pending); end
    #0.2 reset = 1'b1;
    #0.3;
    checks++; if (rows !== 4'b1110 || cmd !== 4'b1111 || key_pending !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%b/%b/%b exp=1110/1111/0", rows, cmd, key_pending); end
    keys = '0;
    status = 2'b10;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    watch(80, p, k, d);
    checks++; if (p !== 0) begin errors++; $display("FAIL discarded_key got=%0d/%b exp=0", p, k); end
  endtask

  initial begin
    test_reset;
    test_single_key;
    test_ready_gating;
    test_bounce;
    test_multi_key;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
